// File: rtl/dt_statistics.sv
// Shared-buffer occupancy tracker with dynamic-threshold admit bitmaps.
// Per-queue byte counters, total/peak watermarks and sticky saturation flags.
module dt_statistics #(
    parameter int NUM_PORTS   = 4,
    parameter int PORT_W      = 2,
    parameter int LEN_W       = 11,
    parameter int QLEN_W      = 16,
    parameter int BUFFER_SIZE = 6400,
    parameter int ALPHA_RST   = 0,
    parameter int DT_MARGIN   = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enq_vld,
    input  logic [PORT_W-1:0]    enq_port,
    input  logic [LEN_W-1:0]     enq_len,
    input  logic                 deq_vld,
    input  logic [PORT_W-1:0]    deq_port,
    input  logic [LEN_W-1:0]     deq_len,
    input  logic                 hd_vld,
    input  logic [PORT_W-1:0]    hd_port,
    input  logic [LEN_W-1:0]     hd_len,
    input  logic                 cfg_we,
    input  logic [PORT_W-1:0]    cfg_port,
    input  logic [2:0]           cfg_alpha,
    input  logic                 peak_clr,
    input  logic                 err_clr,
    output logic [NUM_PORTS-1:0] bitmap,
    output logic [NUM_PORTS-1:0] bitmap_dt,
    output logic [QLEN_W-1:0]    total_occ,
    output logic [QLEN_W-1:0]    peak_occ,
    output logic [NUM_PORTS-1:0] err_underflow,
    output logic [NUM_PORTS-1:0] err_overflow
);

    localparam int CW = QLEN_W + 2;
    localparam int SW = QLEN_W + $clog2(NUM_PORTS + 1);

    localparam logic [CW-1:0]        QMAX_U   = {2'b00, {QLEN_W{1'b1}}};
    localparam logic signed [CW-1:0] QMAX_S   = QMAX_U;
    localparam logic [SW-1:0]        QMAX_SUM = SW'(QMAX_U);
    localparam logic [CW-1:0]        BUF_C    = CW'(BUFFER_SIZE);
    localparam logic [CW-1:0]        MARGIN_C = CW'(DT_MARGIN);

    logic [QLEN_W-1:0]    qlen_q  [NUM_PORTS];
    logic [QLEN_W-1:0]    qlen_d  [NUM_PORTS];
    logic [QLEN_W-1:0]    snap_q  [NUM_PORTS];
    logic [2:0]           alpha_q [NUM_PORTS];
    logic [2:0]           alpha_d [NUM_PORTS];
    logic [QLEN_W-1:0]    total_q, total_d;
    logic [QLEN_W-1:0]    peak_q, peak_d;
    logic [NUM_PORTS-1:0] bm_q, bm_d;
    logic [NUM_PORTS-1:0] bmdt_q, bmdt_d;
    logic [NUM_PORTS-1:0] unf_q, unf_d, unf_set;
    logic [NUM_PORTS-1:0] ovf_q, ovf_d, ovf_set;
    logic [SW-1:0]        sum;
    logic [CW-1:0]        free;

    // All coincident events on a port are folded into one signed step.
    always_comb begin
        logic signed [CW-1:0] acc;
        unf_set = '0;
        ovf_set = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            acc = signed'(CW'(qlen_q[p]));
            if (enq_vld && enq_port == PORT_W'(p))
                acc = acc + signed'(CW'(enq_len));
            if (deq_vld && deq_port == PORT_W'(p))
                acc = acc - signed'(CW'(deq_len));
            if (hd_vld && hd_port == PORT_W'(p))
                acc = acc - signed'(CW'(hd_len));
            unf_set[p] = (acc < 0);
            ovf_set[p] = (acc > QMAX_S);
            if (unf_set[p])
                qlen_d[p] = '0;
            else if (ovf_set[p])
                qlen_d[p] = '1;
            else
                qlen_d[p] = acc[QLEN_W-1:0];
        end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            alpha_d[p] = alpha_q[p];
            if (cfg_we && cfg_port == PORT_W'(p))
                alpha_d[p] = cfg_alpha;
        end
    end

    always_comb begin
        sum = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            sum = sum + SW'(qlen_q[p]);
        total_d = (sum > QMAX_SUM) ? '1 : sum[QLEN_W-1:0];
    end

    // Thresholds use the registered total and its matching qlen snapshot.
    always_comb begin
        logic [CW-1:0] tot_c;
        logic [CW-1:0] thr;
        tot_c = CW'(total_q);
        free  = (tot_c < BUF_C) ? (BUF_C - tot_c) : '0;
        bm_d   = '0;
        bmdt_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            thr       = free >> alpha_q[p];
            bm_d[p]   = (CW'(snap_q[p]) < thr);
            bmdt_d[p] = ((CW'(snap_q[p]) + MARGIN_C) < thr);
        end
    end

    always_comb begin
        unf_d = (err_clr ? '0 : unf_q) | unf_set;
        ovf_d = (err_clr ? '0 : ovf_q) | ovf_set;
        if (peak_clr)
            peak_d = '0;
        else if (total_q > peak_q)
            peak_d = total_q;
        else
            peak_d = peak_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                qlen_q[p]  <= '0;
                snap_q[p]  <= '0;
                alpha_q[p] <= 3'(ALPHA_RST);
            end
            total_q <= '0;
            peak_q  <= '0;
            bm_q    <= '0;
            bmdt_q  <= '0;
            unf_q   <= '0;
            ovf_q   <= '0;
        end else begin
            qlen_q  <= qlen_d;
            snap_q  <= qlen_q;
            alpha_q <= alpha_d;
            total_q <= total_d;
            peak_q  <= peak_d;
            bm_q    <= bm_d;
            bmdt_q  <= bmdt_d;
            unf_q   <= unf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bitmap        = bm_q;
    assign bitmap_dt     = bmdt_q;
    assign total_occ     = total_q;
    assign peak_occ      = peak_q;
    assign err_underflow = unf_q;
    assign err_overflow  = ovf_q;

endmodule

// File: tb/tb_dt_statistics.sv
// Directed bench for dt_statistics: occupancy, thresholds, watermarks, flags.
module tb_dt_statistics;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enq_vld = 1'b0, deq_vld = 1'b0, hd_vld = 1'b0;
    logic [1:0]  enq_port = '0, deq_port = '0, hd_port = '0;
    logic [10:0] enq_len = '0, deq_len = '0, hd_len = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_port = '0;
    logic [2:0]  cfg_alpha = '0;
    logic        peak_clr = 1'b0, err_clr = 1'b0;
    logic [3:0]  bitmap, bitmap_dt, err_underflow, err_overflow;
    logic [15:0] total_occ, peak_occ;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dt_statistics dut (
        .clk(clk), .rst(rst),
        .enq_vld(enq_vld), .enq_port(enq_port), .enq_len(enq_len),
        .deq_vld(deq_vld), .deq_port(deq_port), .deq_len(deq_len),
        .hd_vld(hd_vld), .hd_port(hd_port), .hd_len(hd_len),
        .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_alpha(cfg_alpha),
        .peak_clr(peak_clr), .err_clr(err_clr),
        .bitmap(bitmap), .bitmap_dt(bitmap_dt),
        .total_occ(total_occ), .peak_occ(peak_occ),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_in();
        enq_vld = 0; deq_vld = 0; hd_vld = 0;
        cfg_we = 0; peak_clr = 0; err_clr = 0;
    endtask

    task automatic enq(input logic [1:0] p, input logic [10:0] l);
        enq_vld = 1; enq_port = p; enq_len = l;
    endtask

    task automatic deq(input logic [1:0] p, input logic [10:0] l);
        deq_vld = 1; deq_port = p; deq_len = l;
    endtask

    task automatic hd(input logic [1:0] p, input logic [10:0] l);
        hd_vld = 1; hd_port = p; hd_len = l;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1;
        tick(2);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        enq(0, 100);
        tick(2);
        total++;
        if (total_occ !== 16'd0 || peak_occ !== 16'd0) begin
            $display("FAIL rst_occ total=%0d peak=%0d want 0/0", total_occ, peak_occ);
        end else passed++;
        total++;
        if (bitmap !== 4'b0000 || bitmap_dt !== 4'b0000) begin
            $display("FAIL rst_bitmap bm=%b dt=%b want 0000/0000", bitmap, bitmap_dt);
        end else passed++;
        clr_in();
        rst = 0;
        tick(1);
        total++;
        if (bitmap !== 4'b1111 || bitmap_dt !== 4'b1111) begin
            $display("FAIL rst_first_edge bm=%b dt=%b want 1111/1111", bitmap, bitmap_dt);
        end else passed++;
        tick(2);
        total++;
        if (total_occ !== 16'd0 || bitmap !== 4'b1111 || bitmap_dt !== 4'b1111
            || err_underflow !== 4'b0 || err_overflow !== 4'b0) begin
            $display("FAIL rst_idle total=%0d bm=%b dt=%b uf=%b of=%b want 0/1111/1111/0/0",
                     total_occ, bitmap, bitmap_dt, err_underflow, err_overflow);
        end else passed++;
    endtask

    task automatic test_fill();
        do_reset();
        enq(0, 1500);
        tick(2);
        clr_in();
        tick(1);
        total++;
        if (total_occ !== 16'd3000) begin
            $display("FAIL fill_total2 total=%0d want 3000", total_occ);
        end else passed++;
        tick(1);
        total++;
        if (bitmap !== 4'b1111 || bitmap_dt !== 4'b1111) begin
            $display("FAIL fill_bm2 bm=%b dt=%b want 1111/1111", bitmap, bitmap_dt);
        end else passed++;
        enq(0, 1500);
        tick(1);
        clr_in();
        tick(2);
        total++;
        if (total_occ !== 16'd4500) begin
            $display("FAIL fill_total3 total=%0d want 4500", total_occ);
        end else passed++;
        total++;
        if (bitmap !== 4'b1110 || bitmap_dt !== 4'b1110) begin
            $display("FAIL fill_bm3 bm=%b dt=%b want 1110/1110", bitmap, bitmap_dt);
        end else passed++;
        total++;
        if (peak_occ !== 16'd4500) begin
            $display("FAIL fill_peak peak=%0d want 4500", peak_occ);
        end else passed++;
    endtask

    task automatic test_coincident();
        do_reset();
        enq(1, 1000); deq(1, 400); hd(1, 100);
        tick(1);
        clr_in();
        enq(2, 200);
        tick(1);
        clr_in();
        total++;
        if (total_occ !== 16'd500 || err_underflow !== 4'b0) begin
            $display("FAIL coin_same total=%0d uf=%b want 500/0000", total_occ, err_underflow);
        end else passed++;
        enq(0, 1000); deq(1, 400); hd(2, 100);
        tick(1);
        clr_in();
        tick(1);
        total++;
        if (total_occ !== 16'd1200 || err_underflow !== 4'b0) begin
            $display("FAIL coin_distinct total=%0d uf=%b want 1200/0000", total_occ, err_underflow);
        end else passed++;
        deq(1, 100);
        tick(1);
        clr_in();
        tick(1);
        total++;
        if (total_occ !== 16'd1100 || err_underflow !== 4'b0) begin
            $display("FAIL coin_q1 total=%0d uf=%b want 1100/0000", total_occ, err_underflow);
        end else passed++;
        hd(2, 101);
        tick(1);
        clr_in();
        total++;
        if (err_underflow !== 4'b0100) begin
            $display("FAIL coin_q2_uf uf=%b want 0100", err_underflow);
        end else passed++;
        tick(1);
        total++;
        if (total_occ !== 16'd1000) begin
            $display("FAIL coin_q0 total=%0d want 1000", total_occ);
        end else passed++;
    endtask

    task automatic test_underflow();
        do_reset();
        enq(2, 50);
        tick(1);
        clr_in();
        hd(1, 5); deq(2, 200);
        tick(1);
        clr_in();
        total++;
        if (err_underflow !== 4'b0110) begin
            $display("FAIL uf_set uf=%b want 0110", err_underflow);
        end else passed++;
        tick(2);
        total++;
        if (total_occ !== 16'd0 || err_underflow !== 4'b0110) begin
            $display("FAIL uf_sticky total=%0d uf=%b want 0/0110", total_occ, err_underflow);
        end else passed++;
        err_clr = 1; deq(2, 10);
        tick(1);
        clr_in();
        total++;
        if (err_underflow !== 4'b0100) begin
            $display("FAIL uf_set_wins uf=%b want 0100", err_underflow);
        end else passed++;
        err_clr = 1;
        tick(1);
        clr_in();
        total++;
        if (err_underflow !== 4'b0000) begin
            $display("FAIL uf_clear uf=%b want 0000", err_underflow);
        end else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        enq(3, 2047);
        tick(33);
        clr_in();
        total++;
        if (err_overflow !== 4'b1000 || err_underflow !== 4'b0) begin
            $display("FAIL of_set of=%b uf=%b want 1000/0000", err_overflow, err_underflow);
        end else passed++;
        tick(1);
        total++;
        if (total_occ !== 16'd65535) begin
            $display("FAIL of_clamp total=%0d want 65535", total_occ);
        end else passed++;
        deq(3, 535);
        tick(1);
        clr_in();
        tick(1);
        total++;
        if (total_occ !== 16'd65000 || err_overflow !== 4'b1000) begin
            $display("FAIL of_drain total=%0d of=%b want 65000/1000", total_occ, err_overflow);
        end else passed++;
    endtask

    task automatic test_alpha();
        do_reset();
        cfg_we = 1; cfg_port = 3; cfg_alpha = 3'd2;
        enq(0, 2000);
        tick(1);
        clr_in();
        enq(1, 100);
        tick(1);
        enq(3, 300);
        tick(1);
        clr_in();
        tick(2);
        total++;
        if (total_occ !== 16'd2400 || bitmap !== 4'b1111 || bitmap_dt !== 4'b1111) begin
            $display("FAIL alpha_300 total=%0d bm=%b dt=%b want 2400/1111/1111",
                     total_occ, bitmap, bitmap_dt);
        end else passed++;
        enq(3, 500);
        tick(1);
        clr_in();
        tick(2);
        total++;
        if (total_occ !== 16'd2900 || bitmap !== 4'b1111 || bitmap_dt !== 4'b0111) begin
            $display("FAIL alpha_800 total=%0d bm=%b dt=%b want 2900/1111/0111",
                     total_occ, bitmap, bitmap_dt);
        end else passed++;
        cfg_we = 1; cfg_port = 3; cfg_alpha = 3'd4;
        tick(1);
        clr_in();
        total++;
        if (bitmap !== 4'b1111) begin
            $display("FAIL alpha_cfg_edge bm=%b want 1111", bitmap);
        end else passed++;
        tick(1);
        total++;
        if (bitmap !== 4'b0111 || bitmap_dt !== 4'b0111) begin
            $display("FAIL alpha_cfg_next bm=%b dt=%b want 0111/0111", bitmap, bitmap_dt);
        end else passed++;
    endtask

    task automatic test_peak();
        do_reset();
        enq(0, 2000);
        tick(1);
        enq(1, 2000);
        tick(1);
        enq(2, 2000);
        tick(1);
        enq(3, 1000);
        tick(1);
        clr_in();
        tick(2);
        total++;
        if (total_occ !== 16'd7000 || peak_occ !== 16'd7000) begin
            $display("FAIL peak_full total=%0d peak=%0d want 7000/7000", total_occ, peak_occ);
        end else passed++;
        total++;
        if (bitmap !== 4'b0000 || bitmap_dt !== 4'b0000) begin
            $display("FAIL peak_nofree bm=%b dt=%b want 0000/0000", bitmap, bitmap_dt);
        end else passed++;
        deq(0, 1000);
        tick(1);
        clr_in();
        tick(1);
        total++;
        if (total_occ !== 16'd6000 || peak_occ !== 16'd7000) begin
            $display("FAIL peak_hold total=%0d peak=%0d want 6000/7000", total_occ, peak_occ);
        end else passed++;
        peak_clr = 1;
        tick(1);
        clr_in();
        total++;
        if (peak_occ !== 16'd0) begin
            $display("FAIL peak_clr peak=%0d want 0", peak_occ);
        end else passed++;
        tick(1);
        total++;
        if (peak_occ !== 16'd6000) begin
            $display("FAIL peak_track peak=%0d want 6000", peak_occ);
        end else passed++;
    endtask

    initial begin
        tick(1);
        test_reset();
        test_fill();
        test_coincident();
        test_underflow();
        test_overflow();
        test_alpha();
        test_peak();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dt_statistics.md
DT_STATISTICS -- requirements
Module: dt_statistics

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, meaning number of tracked egress queues.
REQ-002 The block SHALL have parameter PORT_W, default 2, meaning port index width; PORT_W >= clog2(NUM_PORTS).
REQ-003 The block SHALL have parameter LEN_W, default 11, meaning packet length width in bytes.
REQ-004 The block SHALL have parameter QLEN_W, default 16, meaning per-queue and total counter width.
REQ-005 The block SHALL have parameter BUFFER_SIZE, default 6400, meaning shared buffer capacity in bytes.
REQ-006 The block SHALL have parameter ALPHA_RST, default 0, meaning reset value of every per-port alpha shift.
REQ-007 The block SHALL have parameter DT_MARGIN, default 256, meaning headroom in bytes for bitmap_dt.
REQ-008 clk  in  1  sole clock; all state on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 enq_vld / enq_port / enq_len  in  1 / PORT_W / LEN_W  packet admitted to queue enq_port.
REQ-011 deq_vld / deq_port / deq_len  in  1 / PORT_W / LEN_W  packet transmitted from deq_port.
REQ-012 hd_vld / hd_port / hd_len  in  1 / PORT_W / LEN_W  head-drop removal from hd_port.
REQ-013 cfg_we / cfg_port / cfg_alpha  in  1 / PORT_W / 3  write alpha shift of cfg_port.
REQ-014 peak_clr, err_clr  in  1 each  clear peak watermark / sticky error flags.
REQ-015 bitmap, bitmap_dt  out  NUM_PORTS each  per-port admit flags (registered).
REQ-016 total_occ, peak_occ  out  QLEN_W each  registered sum of queues / max total since clear.
REQ-017 err_underflow, err_overflow  out  NUM_PORTS each  sticky per-port saturation flags.

Function
REQ-018 Per port p, each edge, qlen[p] SHALL be updated by +enq_len (if enq_vld and enq_port==p), -deq_len (if deq_vld and deq_port==p), -hd_len (if hd_vld and hd_port==p), all three summed in one step, so any combination of coincident events on equal or distinct ports is exact.
REQ-019 Arithmetic SHALL use QLEN_W+2 signed intermediates; a negative result SHALL clamp qlen[p] to 0 and set err_underflow[p]; a result above 2^QLEN_W-1 SHALL clamp to 2^QLEN_W-1 and set err_overflow[p].
REQ-020 Events with port index >= NUM_PORTS SHALL be ignored without flag change.
REQ-021 total_occ SHALL equal the sum of qlen[] registered one edge after qlen updates (event at edge k visible at edge k+1).
REQ-022 Free space F SHALL be BUFFER_SIZE - total_occ when total_occ < BUFFER_SIZE, else 0.
REQ-023 Threshold T[p] SHALL be F >> alpha[p]; bitmap[p] SHALL register (qlen[p] < T[p]) and bitmap_dt[p] SHALL register (qlen[p] + DT_MARGIN < T[p]), compared unsigned without truncation, from the same qlen snapshot that feeds total_occ, giving both outputs latency 2 edges from an event.
REQ-024 cfg_we SHALL load alpha[cfg_port] at the edge; the new value affects bitmaps from the next edge; out-of-range cfg_port ignored.
REQ-025 peak_occ SHALL load max(peak_occ, total_occ) each edge; peak_clr SHALL load 0 that edge (clear wins).
REQ-026 err_clr SHALL clear all sticky flags; a saturation in the same edge SHALL set its flag (set wins).

Reset
REQ-027 With rst high at an edge, all qlen, total_occ, peak_occ, error flags SHALL become 0, alpha[] ALPHA_RST, bitmap and bitmap_dt 0, with all event and cfg inputs ignored.
REQ-028 From the first edge after rst deasserts, bitmap and bitmap_dt SHALL reflect empty queues (all ones for default parameters).

Verification
REQ-029 Reset then idle 3 cycles -> total_occ 0, bitmap 4'b1111, bitmap_dt 4'b1111.
REQ-030 Enq port0 len 1500 x2 -> total_occ 3000 after 1 edge; F=3400, T=3400; bitmap[0]=1, bitmap_dt[0]=1; third 1500 -> qlen0 4500, F 1900, bitmap[0]=0.
REQ-031 Same edge: enq p1 1000, deq p1 400, hd p1 100 with qlen1 0 -> qlen1 500, no error; repeat all three on distinct ports 0/1/2 -> each queue updated independently.
REQ-032 Deq p2 len 200 with qlen2 50 -> qlen2 0, err_underflow[2]=1 until err_clr; err_clr coinciding with new underflow on p2 -> flag stays 1.
REQ-033 cfg alpha[3]=2, qlen3 300, total 2400 -> T3=1000, bitmap[3]=1, bitmap_dt[3]=1; qlen3 800 (total 2900) -> T3=875, bitmap[3]=1, bitmap_dt[3]=0.
REQ-034 Fill total to 7000 > BUFFER_SIZE -> F=0, bitmap 0; peak_occ 7000; peak_clr -> peak_occ 0 then tracks total_occ next edge.
